// File: rtl/fifo_rd_stream.sv
// Pulls words from a synchronous FIFO with one-cycle read latency and presents
// them as a valid/ready stream, tagging every BURST_LEN-th beat with m_last.
module fifo_rd_stream #(
  parameter int MEMORY_WIDTH = 4,
  parameter int BURST_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    empty,
  input  logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    r_en,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [MEMORY_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic [15:0]             beat_cnt
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  logic [1:0]              occ_q, occ_d;
  logic                    pend_q, pend_d;
  logic [MEMORY_WIDTH-1:0] buf0_q, buf0_d;
  logic [MEMORY_WIDTH-1:0] buf1_q, buf1_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [15:0]             beat_cnt_q, beat_cnt_d;

  logic       pop_s;
  logic [2:0] fill_s;

  // Stream handshake and read strobe; fill_s is the buffer occupancy after this edge.
  always_comb begin
    m_valid  = rst_n && (occ_q != 2'd0);
    pop_s    = m_valid && m_ready;
    fill_s   = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop_s};
    r_en     = rst_n && !empty && (fill_s <= 3'd1);
    m_last   = m_valid && (idx_q == LAST_IDX);
    m_data   = buf0_q;
    beat_cnt = beat_cnt_q;
  end

  // Next-state: shift the head out on pop, then land the arriving word at the tail.
  always_comb begin
    occ_d      = fill_s[1:0];
    pend_d     = r_en;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    idx_d      = idx_q;
    beat_cnt_d = beat_cnt_q;
    if (pop_s) begin
      buf0_d     = buf1_q;
      beat_cnt_d = beat_cnt_q + 16'd1;
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
    if (pend_q) begin
      // Tail slot index equals the occupancy left after the pop.
      if (fill_s == 3'd1) begin
        buf0_d = rdata;
      end else begin
        buf1_d = rdata;
      end
    end else begin
      buf1_d = buf1_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      pend_q     <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      idx_q      <= '0;
      beat_cnt_q <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      idx_q      <= idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: fixed vector table, directed multi-cycle sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_fifo_rd_stream;

  localparam int MW = 4;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          empty = 1'b1;
  logic [MW-1:0] rdata = '0;
  logic          r_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [MW-1:0] m_data;
  logic          m_last;
  logic [15:0]   beat_cnt;

  fifo_rd_stream #(.MEMORY_WIDTH(MW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .rdata(rdata), .r_en(r_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          rdy;
    int            load;
    logic          e_ren;
    logic          e_valid;
    logic [MW-1:0] e_data;
    logic          e_last;
    int            e_cnt;
  } vec_t;

  typedef struct {
    logic [MW-1:0] data;
    int            avail;
  } ent_t;

  vec_t          tbl [0:22];
  logic [MW-1:0] src [$];
  ent_t          exq [$];
  logic [MW-1:0] got_d [$];
  logic          got_l [$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            pops = 0;
  int            mcnt = 0;
  logic          rst_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic rst_v, input logic rdy_v);
    @(negedge clk);
    rst_n   = rst_v;
    m_ready = rdy_v;
    empty   = (src.size() == 0);
    #1;
  endtask

  // Upstream FIFO: a strobe seen at the edge presents its word the following cycle.
  task automatic finish_cycle();
    logic ren_v;
    ren_v = r_en;
    @(posedge clk);
    #1;
    if (ren_v && src.size() > 0) rdata = src.pop_front();
    else rdata = MW'($urandom);
    cyc++;
  endtask

  // One cycle checked against the reference: words leave in read order, each
  // visible two cycles after its strobe, and at most two words outstanding.
  task automatic step(input logic rst_v, input logic rdy_v);
    logic exp_valid, exp_pop, exp_ren;
    drive(rst_v, rdy_v);
    if (!rst_v) begin
      chk("rst_r_en", r_en, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      if (!rst_prev) chk("rst_beat_cnt", beat_cnt, 0);
      exq.delete();
      pops = 0;
      mcnt = 0;
    end else begin
      exp_valid = (exq.size() > 0) && (exq[0].avail <= cyc);
      chk("m_valid", m_valid, exp_valid);
      if (exp_valid) begin
        chk("m_data", m_data, exq[0].data);
        chk("m_last", m_last, ((pops % BL) == BL - 1) ? 1 : 0);
      end else begin
        chk("m_last_idle", m_last, 0);
      end
      chk("beat_cnt", beat_cnt, mcnt);
      exp_pop = exp_valid && rdy_v;
      exp_ren = !empty && ((exq.size() - int'(exp_pop)) <= 1);
      chk("r_en", r_en, exp_ren);
      if (exp_pop) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        void'(exq.pop_front());
        pops++;
        mcnt = (mcnt + 1) % 65536;
      end
      if (exp_ren && src.size() > 0) exq.push_back('{src[0], cyc + 2});
    end
    rst_prev = rst_v;
    finish_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // rst rdy load | r_en valid data last cnt(-1 = skip)
    tbl[0]  = '{1'b0, 1'b1, 5, 1'b0, 1'b0, 4'd0, 1'b0, -1};
    tbl[1]  = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 4'd0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 4'd0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 4'd0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 4'd1, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 4'd2, 1'b0, 1};
    tbl[6]  = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 4'd3, 1'b0, 2};
    tbl[7]  = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 4'd4, 1'b1, 3};
    tbl[8]  = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 4'd5, 1'b0, 4};
    tbl[9]  = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 4'd0, 1'b0, 5};
    tbl[10] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 4'd0, 1'b0, -1};
    tbl[11] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 4'd0, 1'b0, 0};
    tbl[12] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 4'd0, 1'b0, 0};
    tbl[13] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 4'd0, 1'b0, 0};
    tbl[14] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 4'd1, 1'b0, 0};
    tbl[15] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 4'd1, 1'b0, 0};
    tbl[16] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 4'd1, 1'b0, 0};
    tbl[17] = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 4'd1, 1'b0, 0};
    tbl[18] = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 4'd2, 1'b0, 1};
    tbl[19] = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 4'd3, 1'b0, 2};
    tbl[20] = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 4'd4, 1'b1, 3};
    tbl[21] = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 4'd5, 1'b0, 4};
    tbl[22] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 4'd0, 1'b0, 5};

    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      if (tbl[i].load > 0) begin
        src.delete();
        for (int k = 1; k <= tbl[i].load; k++) src.push_back(MW'(k));
      end
      drive(tbl[i].rst, tbl[i].rdy);
      chk($sformatf("tbl%0d_r_en", i), r_en, tbl[i].e_ren);
      chk($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_m_last", i), m_last, tbl[i].e_last);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_m_data", i), m_data, tbl[i].e_data);
      if (tbl[i].e_cnt >= 0) chk($sformatf("tbl%0d_beat_cnt", i), beat_cnt, tbl[i].e_cnt);
      finish_cycle();
    end

    // Alternating readiness over words 1..8.
    src.delete();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) src.push_back(MW'(k));
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < 60 && got_d.size() < 8; c++) step(1'b1, (c % 2) == 0);
    chk("alt_count", got_d.size(), 8);
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      chk($sformatf("alt_word%0d", i), got_d[i], i + 1);
      chk($sformatf("alt_last%0d", i), got_l[i], (i == 3 || i == 7) ? 1 : 0);
    end

    // Reset after two accepted beats, then a fresh burst 9..12.
    src.delete();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) src.push_back(MW'(k));
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < 30 && got_d.size() < 2; c++) step(1'b1, 1'b1);
    chk("mid_pre_count", got_d.size(), 2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    src.delete();
    for (int k = 9; k <= 12; k++) src.push_back(MW'(k));
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < 40 && got_d.size() < 4; c++) step(1'b1, 1'b1);
    chk("mid_count", got_d.size(), 4);
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      chk($sformatf("mid_word%0d", i), got_d[i], i + 9);
      chk($sformatf("mid_last%0d", i), got_l[i], (i == 3) ? 1 : 0);
    end
    step(1'b1, 1'b1);
    chk("mid_beat_cnt", beat_cnt, 4);

    // Empty source: strobe stays low and the buffer drains.
    src.delete();
    for (int c = 0; c < 6; c++) step(1'b1, 1'b1);
    chk("empty_r_en", r_en, 0);
    chk("empty_m_valid", m_valid, 0);

    // Randomized traffic with drain phases and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        step(1'b0, 1'($urandom));
        step(1'b0, 1'($urandom));
      end
      if (((c / 200) % 3) != 2 && $urandom_range(0, 1) == 1 && src.size() < 16)
        src.push_back(MW'($urandom));
      step(1'b1, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter MEMORY_WIDTH, default 4, data word width in bits.
REQ-002 SHALL have parameter BURST_LEN, default 4, beats per burst (2..256).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port empty  input  1  upstream synchronous FIFO empty flag.
REQ-006 SHALL have port rdata  input  MEMORY_WIDTH  FIFO read data, valid the cycle after r_en is sampled high.
REQ-007 SHALL have port r_en  output  1  FIFO read strobe.
REQ-008 SHALL have port m_valid  output  1  output stream word valid.
REQ-009 SHALL have port m_ready  input  1  downstream ready.
REQ-010 SHALL have port m_data  output  MEMORY_WIDTH  output stream word.
REQ-011 SHALL have port m_last  output  1  marks final beat of a burst.
REQ-012 SHALL have port beat_cnt  output  16  total accepted beats since reset.

Function
REQ-013 SHALL contain a 2-entry in-order output buffer (occ = 0..2) and a 1-bit pend flag, set to the registered value of r_en.
REQ-014 SHALL define pop = m_valid && m_ready; a transfer occurs only on pop.
REQ-015 SHALL drive r_en = rst_n && !empty && (occ + pend - pop) <= 1; r_en SHALL never be high while empty = 1.
REQ-016 SHALL, when pend = 1, write rdata into the buffer tail at the end of that cycle.
REQ-017 SHALL drive m_valid = (occ != 0) and m_data = buffer head entry.
REQ-018 SHALL give a latency of 2 cycles from r_en high to the corresponding word on m_data, when the buffer is empty.
REQ-019 SHALL, with simultaneous arrival (pend) and pop, leave occ unchanged, advance the head, and append the new word at the tail.
REQ-020 SHALL hold m_data and m_last stable while m_valid && !m_ready.
REQ-021 SHALL never overflow: occ + pend SHALL not exceed 2 in any cycle.
REQ-022 SHALL keep a beat index 0..BURST_LEN-1; it increments on pop and wraps to 0 after BURST_LEN-1.
REQ-023 SHALL drive m_last = m_valid && (beat index == BURST_LEN-1).
REQ-024 SHALL increment beat_cnt by 1 on each pop, wrapping from 16'hFFFF to 0.
REQ-025 SHALL sustain one transfer per cycle in steady state with empty = 0 and m_ready = 1.
REQ-026 SHALL preserve FIFO order exactly, with no word duplicated or dropped.

Reset
REQ-027 SHALL, while rst_n = 0 at a clk edge, clear occ, pend, beat index and beat_cnt to 0, and set m_data to 0.
REQ-028 SHALL hold r_en = 0, m_valid = 0 and m_last = 0 during reset.
REQ-029 SHALL discard buffered and in-flight words on reset mid-operation; the first post-reset pop SHALL be beat index 0.
REQ-030 SHALL ignore rdata and m_ready during reset.

Verification
REQ-031 SHALL cover reset: rst_n = 0 for 2 cycles, FIFO non-empty -> r_en = 0, m_valid = 0, m_last = 0, beat_cnt = 0.
REQ-032 SHALL cover streaming: FIFO holds 1,2,3,4,5, m_ready = 1 -> m_data = 1..5 on consecutive cycles, first word 2 cycles after first r_en, m_last high on word 4 only, beat_cnt = 5.
REQ-033 SHALL cover backpressure: FIFO holds 1..5, m_ready = 0 -> exactly 2 r_en pulses, m_data held at 1, occ = 2, no further r_en until m_ready rises.
REQ-034 SHALL cover alternating readiness: m_ready toggling every cycle over 8 words 1..8 -> output sequence 1..8 in order with no gaps or duplicates, m_last on words 4 and 8.
REQ-035 SHALL cover reset mid-burst: reset after 2 accepted beats, then 4 new words 9..12 -> m_valid = 0 during reset, m_last on word 12, beat_cnt = 4.
REQ-036 SHALL cover empty: empty held at 1 with m_ready = 1 -> r_en stays 0, m_valid = 0 once the buffer has drained.
